// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the SRAM copy/fill engine.
//   state_e    - engine FSM states
//   STROBE_ON  - asserted level of the active-low SRAM strobes
//   STROBE_OFF - deasserted level of the active-low SRAM strobes
//   RD_LAT     - cycles from a read access edge to SRC_Q holding the word
package sram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StFill,
    StFinish
  } state_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int unsigned RD_LAT = 1;

endpackage

// File: rtl/sram_addr_gen.sv
// sram_addr_gen: loadable base register plus incrementing offset, producing a
// registered SRAM address that wraps modulo 2**ADDR_WIDTH.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset (address returns to 0)
//   i_load  - capture i_base and clear the offset
//   i_step  - advance the offset by one word (ignored while i_load is high)
//   i_base  - base address to load
//   o_addr  - registered address, base + offset
module sram_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [ADDR_WIDTH-1:0] i_base,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_offset;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_base_d;
  logic [ADDR_WIDTH-1:0] w_offset_d;

  always_comb begin
    w_base_d   = r_base;
    w_offset_d = r_offset;
    if (i_load) begin
      w_base_d   = i_base;
      w_offset_d = '0;
    end else if (i_step) begin
      w_offset_d = r_offset + ADDR_WIDTH'(1);
    end
  end

  // The sum is registered so the address pins come straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base   <= '0;
      r_offset <= '0;
      r_addr   <= '0;
    end else begin
      r_base   <= w_base_d;
      r_offset <= w_offset_d;
      r_addr   <= w_base_d + w_offset_d;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/sram_copy_engine.sv
// sram_copy_engine: copies a block of words from a source SRAM port to a
// destination SRAM port, or fills a destination range with a constant, at one
// word per clock. All outputs are registered.
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   start, fill, abort   - request (IDLE only), mode select, cancel
//   src_base, dst_base   - first source / destination address
//   len                  - word count 0..2**ADDR_WIDTH
//   fill_value           - constant written in fill mode
//   busy, done           - transfer in progress, completion pulse
//   SRC_ADDR/CEn/OEn/Q   - source SRAM read port (strobes active low)
//   DST_ADDR/DATA/CEn/WEn/OEn - destination SRAM write port (OEn tied high)
module sram_copy_engine
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  fill,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] SRC_ADDR,
  output logic                  SRC_CEn,
  output logic                  SRC_OEn,
  input  logic [DATA_WIDTH-1:0] SRC_Q,
  output logic [ADDR_WIDTH-1:0] DST_ADDR,
  output logic [DATA_WIDTH-1:0] DST_DATA,
  output logic                  DST_CEn,
  output logic                  DST_WEn,
  output logic                  DST_OEn
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;

  state_e                r_state;
  state_e                w_state_d;
  // Words still to be issued (reads in copy mode, writes in fill mode).
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       w_cnt_d;
  // Read pipeline: bit RD_LAT-1 = word on SRC_Q now, bit RD_LAT = write in flight.
  logic [RD_LAT:0]       r_vld;
  logic [RD_LAT:0]       w_vld_d;
  logic                  r_src_strb;
  logic                  w_src_strb_d;
  logic                  r_dst_strb;
  logic                  w_dst_strb_d;
  logic [DATA_WIDTH-1:0] r_dst_data;
  logic [DATA_WIDTH-1:0] w_dst_data_d;
  logic                  r_busy;
  logic                  w_busy_d;
  logic                  r_done;
  logic                  w_done_d;
  logic                  w_load;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_vld_d      = {r_vld[RD_LAT-1:0], 1'b0};
    w_src_strb_d = STROBE_OFF;
    w_dst_strb_d = STROBE_OFF;
    w_dst_data_d = r_dst_data;
    w_load       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start && !abort) begin
          w_load  = 1'b1;
          w_cnt_d = len;
          if (len == '0) begin
            w_state_d = StFinish;
          end else if (fill) begin
            w_state_d    = StFill;
            w_dst_strb_d = STROBE_ON;
            w_dst_data_d = fill_value;
          end else begin
            w_state_d    = StRead;
            w_src_strb_d = STROBE_ON;
          end
        end
      end
      StRead: begin
        // A read is on the pins this cycle; it enters the pipeline at the edge.
        w_vld_d[0] = 1'b1;
        w_cnt_d    = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_d = StDrain;
        end else begin
          w_src_strb_d = STROBE_ON;
        end
      end
      StDrain: begin
        // Once no word is left to capture, the only remaining write is the one
        // on the pins now, which commits at this edge.
        if (r_vld[RD_LAT-1:0] == '0) begin
          w_state_d = StFinish;
        end
      end
      StFill: begin
        w_cnt_d = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_d = StFinish;
        end else begin
          w_dst_strb_d = STROBE_ON;
        end
      end
      StFinish: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Copy write path: the word on SRC_Q becomes next cycle's write.
    if (r_vld[RD_LAT-1]) begin
      w_dst_strb_d = STROBE_ON;
      w_dst_data_d = SRC_Q;
    end

    if (abort && (r_state != StIdle)) begin
      w_state_d    = StIdle;
      w_vld_d      = '0;
      w_src_strb_d = STROBE_OFF;
      w_dst_strb_d = STROBE_OFF;
    end

    w_busy_d = w_state_d inside {StRead, StDrain, StFill};
    w_done_d = (w_state_d == StFinish);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_vld      <= '0;
      r_src_strb <= STROBE_OFF;
      r_dst_strb <= STROBE_OFF;
      r_dst_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_vld      <= w_vld_d;
      r_src_strb <= w_src_strb_d;
      r_dst_strb <= w_dst_strb_d;
      r_dst_data <= w_dst_data_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
    end
  end

  // Each generator advances after every cycle in which its port was strobed.
  sram_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_src_addr (
    .clk   (clk),
    .reset (reset),
    .i_load(w_load),
    .i_step(r_src_strb == STROBE_ON),
    .i_base(src_base),
    .o_addr(SRC_ADDR)
  );

  sram_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dst_addr (
    .clk   (clk),
    .reset (reset),
    .i_load(w_load),
    .i_step(r_dst_strb == STROBE_ON),
    .i_base(dst_base),
    .o_addr(DST_ADDR)
  );

  assign SRC_CEn  = r_src_strb;
  assign SRC_OEn  = r_src_strb;
  assign DST_CEn  = r_dst_strb;
  assign DST_WEn  = r_dst_strb;
  assign DST_OEn  = STROBE_OFF;
  assign DST_DATA = r_dst_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sram_copy_engine.sv
module tb_sram_copy_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, fill, abort;
  logic [AW-1:0] src_base, dst_base;
  logic [AW:0]   len;
  logic [DW-1:0] fill_value;
  logic          busy, done;
  logic [AW-1:0] SRC_ADDR, DST_ADDR;
  logic          SRC_CEn, SRC_OEn, DST_CEn, DST_WEn, DST_OEn;
  logic [DW-1:0] SRC_Q, DST_DATA;

  always #5 clk = ~clk;

  sram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .fill(fill), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
    .busy(busy), .done(done),
    .SRC_ADDR(SRC_ADDR), .SRC_CEn(SRC_CEn), .SRC_OEn(SRC_OEn), .SRC_Q(SRC_Q),
    .DST_ADDR(DST_ADDR), .DST_DATA(DST_DATA), .DST_CEn(DST_CEn), .DST_WEn(DST_WEn),
    .DST_OEn(DST_OEn)
  );

  // SRAM models: read data valid the cycle after the access edge.
  logic [DW-1:0] src_mem [NW];
  logic [DW-1:0] dst_mem [NW];
  logic [DW-1:0] exp_mem [NW];
  logic          init_go = 1'b0;
  logic [DW-1:0] init_mul, init_add;

  always @(posedge clk) begin
    if (!SRC_CEn && !SRC_OEn) SRC_Q <= src_mem[SRC_ADDR];
    if (init_go) begin
      for (int i = 0; i < NW; i++) dst_mem[i] <= DW'(i) * init_mul + init_add;
    end else if (!DST_CEn && !DST_WEn) begin
      dst_mem[DST_ADDR] <= DST_DATA;
    end
  end

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  acc_t o_rd[$], o_wr[$], e_rd[$], e_wr[$];
  int   o_done_cyc, o_ndone, o_nbusy, o_busy_first, o_busy_last, o_strb_err;
  int   e_done_cyc, e_nbusy;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    logic          f;
    logic [AW-1:0] sb, db;
    logic [AW:0]   n;
    logic [DW-1:0] fv;
    logic [DW-1:0] imul, iadd;
    int            abort_at;   // -1 none, 0 together with start
    int            start2_at;  // -1 none
    int            x_done;     // 0 = no done pulse expected
    int            x_busy, x_wr, x_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic init_dst(input logic [DW-1:0] m, input logic [DW-1:0] a);
    init_mul = m;
    init_add = a;
    for (int i = 0; i < NW; i++) exp_mem[i] = DW'(i) * m + a;
    @(negedge clk) init_go = 1'b1;
    @(negedge clk) init_go = 1'b0;
  endtask

  // Reference: word i is read in cycle 1+i, written in cycle 3+i (copy) or
  // 1+i (fill); an abort in cycle a keeps only activity in cycles <= a.
  task automatic model_op(input logic f, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                          input logic [AW:0] n, input logic [DW-1:0] fv, input int a);
    int last_busy, n_i, wcyc;
    acc_t t;
    e_rd.delete();
    e_wr.delete();
    n_i       = int'(n);
    last_busy = (n_i == 0) ? 0 : (f ? n_i : n_i + 2);
    if (a < 0) begin
      e_nbusy    = last_busy;
      e_done_cyc = (n_i == 0) ? 1 : (f ? n_i + 1 : n_i + 3);
    end else begin
      e_nbusy    = (a < last_busy) ? a : last_busy;
      e_done_cyc = 0;
    end
    for (int i = 0; i < n_i; i++) begin
      if (!f && (a < 0 || 1 + i <= a)) begin
        t.cyc = 32'(1 + i); t.addr = sb + AW'(i); t.data = '0;
        e_rd.push_back(t);
      end
      wcyc = f ? 1 + i : 3 + i;
      if (a < 0 || wcyc <= a) begin
        t.cyc  = 32'(wcyc);
        t.addr = db + AW'(i);
        t.data = f ? fv : src_mem[sb + AW'(i)];
        e_wr.push_back(t);
        exp_mem[t.addr] = t.data;
      end
    end
  endtask

  task automatic run_op(input logic f, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                        input logic [AW:0] n, input logic [DW-1:0] fv, input int a,
                        input int s2, input int ncyc);
    acc_t t;
    o_rd.delete();
    o_wr.delete();
    o_done_cyc = 0; o_ndone = 0; o_nbusy = 0; o_busy_first = 0; o_busy_last = 0;
    o_strb_err = 0;
    @(negedge clk);
    start = 1'b1; fill = f; src_base = sb; dst_base = db; len = n; fill_value = fv;
    abort = (a == 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (done) begin
        o_ndone++;
        if (o_done_cyc == 0) o_done_cyc = cyc;
      end
      if (busy) begin
        o_nbusy++;
        o_busy_last = cyc;
        if (o_busy_first == 0) o_busy_first = cyc;
      end
      if (!SRC_CEn) begin
        t.cyc = 32'(cyc); t.addr = SRC_ADDR; t.data = '0;
        o_rd.push_back(t);
      end
      if (!DST_CEn) begin
        t.cyc = 32'(cyc); t.addr = DST_ADDR; t.data = DST_DATA;
        o_wr.push_back(t);
      end
      if (SRC_CEn != SRC_OEn || DST_CEn != DST_WEn || DST_OEn != 1'b1) o_strb_err++;
      if (cyc == a) abort = 1'b1;
      if (cyc == s2) begin
        start = 1'b1; fill = ~f; src_base = sb + AW'(5); dst_base = db + AW'(7);
        len = n + 2; fill_value = ~fv;
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic compare_op(input string nm);
    int bad, mm;
    chk({nm, " done_cyc"}, o_done_cyc, e_done_cyc);
    chk({nm, " done_pulses"}, o_ndone, (e_done_cyc != 0) ? 1 : 0);
    chk({nm, " busy_cycles"}, o_nbusy, e_nbusy);
    chk({nm, " busy_last"}, o_busy_last, e_nbusy);
    chk({nm, " strobe_pairing"}, o_strb_err, 0);
    chk({nm, " reads"}, o_rd.size(), e_rd.size());
    chk({nm, " writes"}, o_wr.size(), e_wr.size());
    bad = 0;
    if (o_rd.size() == e_rd.size()) foreach (o_rd[i]) if (o_rd[i] != e_rd[i]) bad++;
    chk({nm, " read_seq_err"}, bad, 0);
    bad = 0;
    if (o_wr.size() == e_wr.size()) foreach (o_wr[i]) if (o_wr[i] != e_wr[i]) bad++;
    chk({nm, " write_seq_err"}, bad, 0);
    mm = 0;
    for (int i = 0; i < NW; i++) if (dst_mem[i] != exp_mem[i]) mm++;
    chk({nm, " dst_mem_err"}, mm, 0);
  endtask

  task automatic do_op(input string nm, input logic f, input logic [AW-1:0] sb,
                       input logic [AW-1:0] db, input logic [AW:0] n, input logic [DW-1:0] fv,
                       input logic [DW-1:0] im, input logic [DW-1:0] ia, input int a,
                       input int s2);
    init_dst(im, ia);
    model_op(f, sb, db, n, fv, a);
    run_op(f, sb, db, n, fv, a, s2, int'(n) + 6);
    compare_op(nm);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t0_data [4];
    logic          rf;
    logic [AW:0]   rn;
    int            ra, rs, lb;

    t0_data[0] = 8'hA1; t0_data[1] = 8'hB2; t0_data[2] = 8'hC3; t0_data[3] = 8'hD4;
    for (int i = 0; i < NW; i++) src_mem[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) src_mem['h010 + i] = t0_data[i];

    //            f     sb      db      n     fv     imul   iadd   ab  s2  done busy wr  rd
    vecs[0] = '{1'b0, 10'h010, 10'h200, 11'd4,    8'h00, 8'h03, 8'h11, -1, -1, 7,    6,   4,   4};
    vecs[1] = '{1'b0, 10'h3FE, 10'h3FF, 11'd4,    8'h00, 8'h05, 8'h22, -1, -1, 7,    6,   4,   4};
    vecs[2] = '{1'b1, 10'h000, 10'h000, 11'd1024, 8'h00, 8'h00, 8'hFF, -1, -1, 1025, 1024, 1024, 0};
    vecs[3] = '{1'b0, 10'h123, 10'h321, 11'd0,    8'h00, 8'h07, 8'h33, -1, -1, 1,    0,   0,   0};
    vecs[4] = '{1'b0, 10'h040, 10'h100, 11'd8,    8'h00, 8'h09, 8'h44,  5, -1, 0,    5,   3,   5};
    vecs[5] = '{1'b0, 10'h010, 10'h280, 11'd4,    8'h00, 8'h0B, 8'h55, -1,  2, 7,    6,   4,   4};
    vecs[6] = '{1'b0, 10'h010, 10'h080, 11'd4,    8'h00, 8'h0D, 8'h66,  0, -1, 0,    0,   0,   0};
    vecs[7] = '{1'b1, 10'h000, 10'h3FE, 11'd3,    8'h5A, 8'h0F, 8'h77,  2, -1, 0,    2,   2,   0};
    vecs[8] = '{1'b0, 10'h3FF, 10'h000, 11'd1,    8'h00, 8'h11, 8'h88, -1, -1, 4,    3,   1,   1};

    reset = 1'b1; start = 1'b0; fill = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; len = '0; fill_value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset strobes", {SRC_CEn, SRC_OEn, DST_CEn, DST_WEn, DST_OEn}, 5'b11111);
    chk("reset src_addr", SRC_ADDR, 0);
    chk("reset dst_addr", DST_ADDR, 0);
    chk("reset dst_data", DST_DATA, 0);
    reset = 1'b0;

    for (int k = 0; k < 9; k++) begin
      do_op($sformatf("v%0d", k), vecs[k].f, vecs[k].sb, vecs[k].db, vecs[k].n, vecs[k].fv,
            vecs[k].imul, vecs[k].iadd, vecs[k].abort_at, vecs[k].start2_at);
      chk($sformatf("v%0d tab_done", k), o_done_cyc, vecs[k].x_done);
      chk($sformatf("v%0d tab_busy", k), o_nbusy, vecs[k].x_busy);
      chk($sformatf("v%0d tab_wr", k), o_wr.size(), vecs[k].x_wr);
      chk($sformatf("v%0d tab_rd", k), o_rd.size(), vecs[k].x_rd);
      if (k == 0) begin
        for (int i = 0; i < 4; i++) chk($sformatf("v0 dst[%0d]", i), dst_mem['h200 + i], t0_data[i]);
      end
    end

    // Reset in the middle of a copy.
    init_dst(8'h01, 8'h00);
    @(negedge clk);
    start = 1'b1; fill = 1'b0; src_base = 10'h050; dst_base = 10'h150; len = 11'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("midrst busy_before", busy, 1);
    chk("midrst write_active_before", DST_CEn, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst strobes", {SRC_CEn, SRC_OEn, DST_CEn, DST_WEn, DST_OEn}, 5'b11111);
    chk("midrst src_addr", SRC_ADDR, 0);
    chk("midrst dst_addr", DST_ADDR, 0);
    chk("midrst dst_data", DST_DATA, 0);
    reset = 1'b0;
    do_op("post_reset len0", 1'b0, 10'h001, 10'h002, 11'd0, 8'h00, 8'h02, 8'h01, -1, -1);

    // Randomized operations against the reference model.
    for (int r = 0; r < 30; r++) begin
      rf = 1'($urandom_range(0, 1));
      rn = 11'($urandom_range(0, 40));
      lb = (rn == 0) ? 0 : (rf ? int'(rn) : int'(rn) + 2);
      ra = -1;
      rs = -1;
      if (lb > 0 && $urandom_range(0, 3) == 0) ra = $urandom_range(0, lb);
      else if (lb > 0 && $urandom_range(0, 3) == 0) rs = $urandom_range(1, lb);
      do_op($sformatf("rnd%0d", r), rf, AW'($urandom), AW'($urandom), rn, DW'($urandom),
            DW'($urandom), DW'($urandom), ra, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
